ttt_nxn_game_ctrl: RTL
======================

Name: ttt_nxn_game_ctrl

Overview:
- Parametrised successor of the 3x3 tic-tac-toe controller. Plays an NxN board where a player wins by filling a full row, column or diagonal.
- Accepts moves through a valid/ready handshake and rejects illegal moves.
- Detects wins and draws, keeps saturating per-player scores, and can alternate which player opens each game.
- Sits between the input/move-select logic and the VGA board renderer, which reads Board_flat.

Parameters:
N, 3, board side length (legal range 3..8); win length equals N.
SCORE_W, 12, width of each score counter.
ALT_FIRST, 0, 0 = X always opens; 1 = opener alternates each game, starting with X after reset.
RC_W, derived = max(1, clog2(N)), width of row/column indices (localparam).

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
Start  in  1  leave INI and begin first game
Ack  in  1  in DONE: start next game, scores kept
Quit  in  1  in DONE: return to INI (scores cleared there); Ack has priority
Move_valid  in  1  move request
Move_row  in  RC_W  target row
Move_col  in  RC_W  target column
Move_ready  out  1  high in XTU/OTU (combinational from state)
Move_err  out  1  one-cycle pulse: illegal move rejected
Board_flat  out  2*N*N  cell (r,c) at bits [2*(r*N+c)+1 : 2*(r*N+c)]; 00 empty, 01 X, 10 O
Xwins  out  1  X won current game (held until STA)
Owins  out  1  O won current game (held until STA)
Draw  out  1  board full, no winner (held until STA)
P1s  out  SCORE_W  X score
P2s  out  SCORE_W  O score
Qi, Qs, Qx, Qo, Qc, Qd  out  1 each  one-hot state: INI, STA, XTU, OTU, CHK, DONE

Behaviour:
- Reset (async, Reset_n=0): state=INI; board all 00; move counter=0; Xwins=Owins=Draw=0; P1s=P2s=0; Move_err=0; opener=X. Every register has a defined reset value (no X).
- INI: P1s, P2s <= 0; opener <= X. Start=1 -> STA.
- STA (one cycle): board cleared; counter <= 0; flags <= 0. Next state is XTU or OTU per the current opener.
- XTU/OTU: a move is accepted on a clock edge when Move_valid & Move_ready.
  - Legal (row<N, col<N, cell empty): write 01 (XTU) or 10 (OTU), counter+1, latch row/col and mover, go to CHK.
  - Illegal: Move_err=1 for that cycle; state, board and counter unchanged; the same player moves again.
  - Move_valid=0: hold.
- CHK (exactly one cycle; latency from accept to result is 2 edges). Using the latched cell, test its row, its column, the main diagonal if row==col, and the anti-diagonal if row+col==N-1. A line wins when all N cells equal the mover's code.
  - Win: set Xwins or Owins; increment P1s or P2s, saturating at 2^SCORE_W-1; go to DONE.
  - Else if counter==N*N: Draw <= 1; go to DONE. A win on the last cell is a win, not a draw.
  - Else: go to the other player's turn.
- DONE: Move_ready=0 and moves are ignored.
  - Ack -> STA; if ALT_FIRST=1, opener toggles.
  - Else Quit -> INI.
  - Start is ignored.
- Counter width is clog2(N*N+1). Illegal or unreachable state encoding -> INI, with no other register change.
- Asserting Reset_n=0 mid-game aborts immediately to the reset values.

Test Plan:
- N=3: reset, Start, moves X(0,0) O(1,0) X(0,1) O(1,1) X(0,2) -> CHK then DONE; Xwins=1, P1s=1, P2s=0; Board_flat[5:0]=010101.
- N=3: O wins via anti-diagonal (0,2),(1,1),(2,0) -> Owins=1, P2s=1; Ack -> STA clears board and flags, P2s stays 1.
- N=3: sequence filling all 9 cells with no line -> Draw=1 after the 9th move, no score change. Separately, a 9th move completing a line -> Xwins=1, Draw=0.
- Illegal moves: a move to an occupied cell, and row=3 with N=3 -> Move_err pulses 1 cycle; board and counter unchanged; same player stays in its turn state.
- ALT_FIRST=1, N=4: game 1 opens in XTU; Ack -> game 2 opens in OTU; a 4-in-column win is detected. SCORE_W=2: after 4 X wins, P1s stays 3.
- Reset_n pulled low while in OTU with 5 cells filled -> next cycle state INI, Board_flat=0, scores 0. Quit in DONE -> INI clears P1s/P2s.

Source files
------------

// File: rtl/ttt_nxn_game_ctrl.sv
// NxN tic-tac-toe game controller.
// Takes moves over a valid/ready handshake, keeps the board, and detects wins
// and draws. Keeps saturating per-player scores and can alternate the opener.
//
// state | meaning
// ------+-------------------------------------------------------------
// INI   | idle after reset or quit; scores cleared, opener set to X
// STA   | one cycle: clear board, move counter and result flags
// XTU   | X to move
// OTU   | O to move
// CHK   | one cycle: test the lines through the last placed cell
// DONE  | game over; Ack starts the next game, Quit returns to INI
module ttt_nxn_game_ctrl #(
   parameter int N         = 3,
   parameter int SCORE_W   = 12,
   parameter int ALT_FIRST = 0,
   localparam int RC_W     = ($clog2(N) > 1) ? $clog2(N) : 1
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 Start,
   input  logic                 Ack,
   input  logic                 Quit,
   input  logic                 Move_valid,
   input  logic [RC_W-1:0]      Move_row,
   input  logic [RC_W-1:0]      Move_col,
   output logic                 Move_ready,
   output logic                 Move_err,
   output logic [2*N*N-1:0]     Board_flat,
   output logic                 Xwins,
   output logic                 Owins,
   output logic                 Draw,
   output logic [SCORE_W-1:0]   P1s,
   output logic [SCORE_W-1:0]   P2s,
   output logic                 Qi,
   output logic                 Qs,
   output logic                 Qx,
   output logic                 Qo,
   output logic                 Qc,
   output logic                 Qd
);

   localparam int CELLS = N * N;
   localparam int CNT_W = $clog2(CELLS + 1);
   localparam logic [RC_W:0] N_EXT = (RC_W + 1)'(N);
   localparam logic [RC_W:0] N_M1  = (RC_W + 1)'(N - 1);

   localparam logic [2:0] S_INI  = 3'd0;
   localparam logic [2:0] S_STA  = 3'd1;
   localparam logic [2:0] S_XTU  = 3'd2;
   localparam logic [2:0] S_OTU  = 3'd3;
   localparam logic [2:0] S_CHK  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   logic [2:0]           state, state_nx;
   logic [2*CELLS-1:0]   board;
   logic [CNT_W-1:0]     cnt;
   logic [RC_W-1:0]      lrow, lcol;
   logic                 mover;     // 0 = X, 1 = O
   logic                 opener;    // 0 = X, 1 = O
   logic                 xw, ow, dr;
   logic [SCORE_W-1:0]   p1, p2;
   logic                 in_range, cell_empty, legal, turn, accept;
   logic [1:0]           code;
   logic                 row_ok, col_ok, diag_ok, anti_ok, win, full;

   assign turn   = (state == S_XTU) || (state == S_OTU);
   assign accept = turn && Move_valid && legal;
   assign full   = (cnt == CNT_W'(CELLS));
   assign code   = mover ? 2'b10 : 2'b01;

   // Legality of the requested cell: inside the board and still empty.
   always_comb begin
      in_range   = ({1'b0, Move_row} < N_EXT) && ({1'b0, Move_col} < N_EXT);
      cell_empty = 1'b0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            if (Move_row == RC_W'(r) && Move_col == RC_W'(c))
               cell_empty = (board[2*(r*N+c) +: 2] == 2'b00);
      legal = in_range && cell_empty;
   end

   // Only lines through the latched cell can have just been completed.
   always_comb begin
      row_ok  = 1'b1;
      col_ok  = 1'b1;
      diag_ok = 1'b1;
      anti_ok = 1'b1;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            if (lrow == RC_W'(r) && board[2*(r*N+c) +: 2] != code) row_ok = 1'b0;
            if (lcol == RC_W'(c) && board[2*(r*N+c) +: 2] != code) col_ok = 1'b0;
            if (r == c && board[2*(r*N+c) +: 2] != code) diag_ok = 1'b0;
            if (r + c == N - 1 && board[2*(r*N+c) +: 2] != code) anti_ok = 1'b0;
         end
      win = row_ok || col_ok
         || ((lrow == lcol) && diag_ok)
         || ((({1'b0, lrow} + {1'b0, lcol}) == N_M1) && anti_ok);
   end

   // State register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= S_INI;
      else          state <= state_nx;
   end

   // Next-state logic; unused encodings fall back to INI.
   always_comb begin
      state_nx = S_INI;
      case (state)
         S_INI:  state_nx = Start ? S_STA : S_INI;
         S_STA:  state_nx = opener ? S_OTU : S_XTU;
         S_XTU:  state_nx = accept ? S_CHK : S_XTU;
         S_OTU:  state_nx = accept ? S_CHK : S_OTU;
         S_CHK: begin
            if (win || full) state_nx = S_DONE;
            else             state_nx = mover ? S_XTU : S_OTU;
         end
         S_DONE: begin
            if (Ack)       state_nx = S_STA;
            else if (Quit) state_nx = S_INI;
            else           state_nx = S_DONE;
         end
         default: state_nx = S_INI;
      endcase
   end

   // State decode and handshake outputs.
   always_comb begin
      Qi         = (state == S_INI);
      Qs         = (state == S_STA);
      Qx         = (state == S_XTU);
      Qo         = (state == S_OTU);
      Qc         = (state == S_CHK);
      Qd         = (state == S_DONE);
      Move_ready = turn;
      Move_err   = turn && Move_valid && !legal;
   end

   // Board, move counter, result flags, scores and opener.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         board  <= '0;
         cnt    <= '0;
         lrow   <= '0;
         lcol   <= '0;
         mover  <= 1'b0;
         opener <= 1'b0;
         xw     <= 1'b0;
         ow     <= 1'b0;
         dr     <= 1'b0;
         p1     <= '0;
         p2     <= '0;
      end else begin
         case (state)
            S_INI: begin
               p1     <= '0;
               p2     <= '0;
               opener <= 1'b0;
            end
            S_STA: begin
               board <= '0;
               cnt   <= '0;
               xw    <= 1'b0;
               ow    <= 1'b0;
               dr    <= 1'b0;
            end
            S_XTU, S_OTU: begin
               if (accept) begin
                  for (int r = 0; r < N; r++)
                     for (int c = 0; c < N; c++)
                        if (Move_row == RC_W'(r) && Move_col == RC_W'(c))
                           board[2*(r*N+c) +: 2] <= (state == S_OTU) ? 2'b10 : 2'b01;
                  cnt   <= cnt + CNT_W'(1);
                  lrow  <= Move_row;
                  lcol  <= Move_col;
                  mover <= (state == S_OTU);
               end
            end
            S_CHK: begin
               if (win) begin
                  if (mover) begin
                     ow <= 1'b1;
                     if (p2 != '1) p2 <= p2 + SCORE_W'(1);
                  end else begin
                     xw <= 1'b1;
                     if (p1 != '1) p1 <= p1 + SCORE_W'(1);
                  end
               end else if (full) begin
                  dr <= 1'b1;
               end
            end
            S_DONE: begin
               if (Ack && ALT_FIRST != 0) opener <= ~opener;
            end
            default: ;
         endcase
      end
   end

   assign Board_flat = board;
   assign Xwins      = xw;
   assign Owins      = ow;
   assign Draw       = dr;
   assign P1s        = p1;
   assign P2s        = p2;

endmodule
